ball_motion_engine: RTL and testbench

BALL_MOTION_ENGINE -- requirements
Module: ball_motion_engine

---
 rtl/ball_pkg.sv | 53 +++++
 rtl/ball_motion_engine_if.sv | 31 +++
 rtl/ball_renderer.sv | 43 ++++
 rtl/ball_motion_engine.sv | 170 +++++++++++++++++
 tb/tb_ball_motion_engine.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ball_pkg.sv
// Shared types and constants for the ball motion engine: FSM encoding, default colours,
// and the per-axis move/clamp helper used by both motion modes.
package ball_pkg;

    localparam int unsigned PosW   = 10;
    localparam int unsigned ArithW = 11;

    localparam logic [2:0] DefBallRgb = 3'b111;
    localparam logic [2:0] DefBgRgb   = 3'b000;

    typedef enum logic [1:0] {
        StIdle,
        StUpdX,
        StUpdY,
        StDone
    } state_e;

    typedef struct packed {
        logic [ArithW-1:0] pos;
        logic              hit;
    } move_t;

    // hit flags that the move reached or crossed the limit on its side of travel.
    function automatic move_t axis_move(input logic [ArithW-1:0] pos,
                                        input logic [ArithW-1:0] spd,
                                        input logic [ArithW-1:0] lim,
                                        input logic              fwd);
        move_t             res;
        logic [ArithW-1:0] sum;
        res.pos = pos;
        res.hit = 1'b0;
        sum     = pos + spd;
        if (spd != '0) begin
            if (fwd) begin
                if (sum >= lim) begin
                    res.pos = lim;
                    res.hit = 1'b1;
                end else begin
                    res.pos = sum;
                end
            end else begin
                if (pos <= spd) begin
                    res.pos = '0;
                    res.hit = 1'b1;
                end else begin
                    res.pos = pos - spd;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ball_motion_engine_if.sv
// Video timing, button, speed and result signals of the ball motion engine.
interface ball_motion_engine_if #(
    parameter int unsigned SPEED_W = 3
);
    logic               i_vsync;
    logic               i_visible;
    logic [9:0]         i_hpos;
    logic [9:0]         i_vpos;
    logic               i_up;
    logic               i_down;
    logic               i_left;
    logic               i_right;
    logic [SPEED_W-1:0] i_speed;
    logic [9:0]         o_ball_x;
    logic [9:0]         o_ball_y;
    logic [2:0]         o_rgb;
    logic               o_bounce;
    logic               o_busy;

    modport slave (
        input  i_vsync, i_visible, i_hpos, i_vpos,
        input  i_up, i_down, i_left, i_right, i_speed,
        output o_ball_x, o_ball_y, o_rgb, o_bounce, o_busy
    );

    modport master (
        output i_vsync, i_visible, i_hpos, i_vpos,
        output i_up, i_down, i_left, i_right, i_speed,
        input  o_ball_x, o_ball_y, o_rgb, o_bounce, o_busy
    );
endinterface

// File: rtl/ball_renderer.sv
// Pixel hit-test against the ball square with a registered colour output.
module ball_renderer
    import ball_pkg::*;
#(
    parameter int unsigned BALL_SIZE = 16,
    parameter logic [2:0]  BALL_RGB  = DefBallRgb,
    parameter logic [2:0]  BG_RGB    = DefBgRgb
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_visible,
    input  logic [9:0] i_hpos,
    input  logic [9:0] i_vpos,
    input  logic [9:0] i_ball_x,
    input  logic [9:0] i_ball_y,
    output logic [2:0] o_rgb
);
    logic [ArithW-1:0] w_x_end;
    logic [ArithW-1:0] w_y_end;
    logic              w_in_x;
    logic              w_in_y;
    logic [2:0]        r_rgb;

    assign w_x_end = {1'b0, i_ball_x} + ArithW'(BALL_SIZE);
    assign w_y_end = {1'b0, i_ball_y} + ArithW'(BALL_SIZE);
    assign w_in_x  = (i_hpos >= i_ball_x) && ({1'b0, i_hpos} < w_x_end);
    assign w_in_y  = (i_vpos >= i_ball_y) && ({1'b0, i_vpos} < w_y_end);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rgb <= 3'b000;
        end else if (!i_visible) begin
            r_rgb <= 3'b000;
        end else if (w_in_x && w_in_y) begin
            r_rgb <= BALL_RGB;
        end else begin
            r_rgb <= BG_RGB;
        end
    end

    assign o_rgb = r_rgb;

endmodule

// File: rtl/ball_motion_engine.sv
// Frame-ticked ball position FSM (absolute button drive or autonomous bounce) feeding
// a registered pixel renderer.
module ball_motion_engine
    import ball_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned BALL_SIZE   = 16,
    parameter int unsigned SPEED_W     = 3,
    parameter int unsigned BOUNCE_MODE = 0,
    parameter logic [2:0]  BALL_RGB    = DefBallRgb,
    parameter logic [2:0]  BG_RGB      = DefBgRgb
) (
    input logic                 i_clk,
    input logic                 i_reset,
    ball_motion_engine_if.slave bus
);
    localparam logic [ArithW-1:0] XMAX  = ArithW'(H_VISIBLE - BALL_SIZE);
    localparam logic [ArithW-1:0] YMAX  = ArithW'(V_VISIBLE - BALL_SIZE);
    localparam logic [PosW-1:0]   X_RST = XMAX[ArithW-1:1];
    localparam logic [PosW-1:0]   Y_RST = YMAX[ArithW-1:1];

    state_e             r_state;
    state_e             w_state_d;
    logic               r_vsync;
    logic               w_tick;
    logic               w_start;

    logic [SPEED_W-1:0] r_speed;
    logic               r_up;
    logic               r_down;
    logic               r_left;
    logic               r_right;

    logic [PosW-1:0]    r_ball_x;
    logic [PosW-1:0]    r_ball_y;
    logic               r_dir_x;
    logic               r_dir_y;
    logic               r_bnc_x;
    logic               r_bnc_y;

    logic               w_x_lone;
    logic               w_y_lone;
    logic               w_x_fwd;
    logic               w_y_fwd;
    logic               w_x_apply;
    logic               w_y_apply;
    move_t              w_x_mv;
    move_t              w_y_mv;
    logic [2:0]         w_rgb;

    assign w_tick  = bus.i_vsync & ~r_vsync;
    assign w_start = (r_state == StIdle) && w_tick;

    // History resets high so a vsync already high at release is not taken as a tick.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_vsync <= 1'b1;
        end else begin
            r_vsync <= bus.i_vsync;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_tick) w_state_d = StUpdX;
            StUpdX:  w_state_d = StUpdY;
            StUpdY:  w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_speed <= '0;
            r_up    <= 1'b0;
            r_down  <= 1'b0;
            r_left  <= 1'b0;
            r_right <= 1'b0;
        end else if (w_start) begin
            r_speed <= bus.i_speed;
            r_up    <= bus.i_up;
            r_down  <= bus.i_down;
            r_left  <= bus.i_left;
            r_right <= bus.i_right;
        end
    end

    assign w_x_lone = r_left ^ r_right;
    assign w_y_lone = r_up ^ r_down;

    // A lone button picks the travel direction; otherwise bounce mode keeps its own.
    always_comb begin
        w_x_fwd   = r_dir_x;
        w_y_fwd   = r_dir_y;
        w_x_apply = 1'b1;
        w_y_apply = 1'b1;
        if (BOUNCE_MODE == 0 || w_x_lone) w_x_fwd = r_right;
        if (BOUNCE_MODE == 0 || w_y_lone) w_y_fwd = r_down;
        if (BOUNCE_MODE == 0) begin
            w_x_apply = w_x_lone;
            w_y_apply = w_y_lone;
        end
    end

    assign w_x_mv = axis_move({1'b0, r_ball_x}, ArithW'(r_speed), XMAX, w_x_fwd);
    assign w_y_mv = axis_move({1'b0, r_ball_y}, ArithW'(r_speed), YMAX, w_y_fwd);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ball_x <= X_RST;
            r_ball_y <= Y_RST;
            r_dir_x  <= 1'b1;
            r_dir_y  <= 1'b1;
            r_bnc_x  <= 1'b0;
            r_bnc_y  <= 1'b0;
        end else begin
            if (w_start) begin
                r_bnc_x <= 1'b0;
                r_bnc_y <= 1'b0;
            end
            if (r_state == StUpdX && w_x_apply) begin
                r_ball_x <= w_x_mv.pos[PosW-1:0];
                if (BOUNCE_MODE != 0) begin
                    r_dir_x <= w_x_mv.hit ? ~w_x_fwd : w_x_fwd;
                    r_bnc_x <= w_x_mv.hit;
                end
            end
            if (r_state == StUpdY && w_y_apply) begin
                r_ball_y <= w_y_mv.pos[PosW-1:0];
                if (BOUNCE_MODE != 0) begin
                    r_dir_y <= w_y_mv.hit ? ~w_y_fwd : w_y_fwd;
                    r_bnc_y <= w_y_mv.hit;
                end
            end
        end
    end

    ball_renderer #(
        .BALL_SIZE(BALL_SIZE),
        .BALL_RGB (BALL_RGB),
        .BG_RGB   (BG_RGB)
    ) u_renderer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_visible(bus.i_visible),
        .i_hpos   (bus.i_hpos),
        .i_vpos   (bus.i_vpos),
        .i_ball_x (r_ball_x),
        .i_ball_y (r_ball_y),
        .o_rgb    (w_rgb)
    );

    assign bus.o_ball_x = r_ball_x;
    assign bus.o_ball_y = r_ball_y;
    assign bus.o_rgb    = w_rgb;
    assign bus.o_bounce = (r_state == StDone) && (r_bnc_x || r_bnc_y);
    assign bus.o_busy   = (r_state != StIdle);

endmodule

// File: tb/tb_ball_motion_engine.sv
// Directed bench: one instance per motion mode, table-driven render and move vectors.
module tb_ball_motion_engine;

    typedef struct {
        logic vis;
        int   h;
        int   v;
        int   e0;
        int   e1;
    } rv_t;

    typedef struct {
        logic u;
        logic d;
        logic l;
        logic r;
        int   spd;
        int   ex;
        int   ey;
    } mv_t;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    ball_motion_engine_if #(.SPEED_W(3)) bus0 ();
    ball_motion_engine_if #(.SPEED_W(3)) bus1 ();

    ball_motion_engine #(
        .BOUNCE_MODE(0)
    ) u_dut0 (
        .i_clk  (clk),
        .i_reset(rst0),
        .bus    (bus0)
    );

    ball_motion_engine #(
        .BOUNCE_MODE(1),
        .BALL_RGB   (3'b101),
        .BG_RGB     (3'b010)
    ) u_dut1 (
        .i_clk  (clk),
        .i_reset(rst1),
        .bus    (bus1)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic btn(input int dut, input logic u, input logic d, input logic l,
                       input logic r, input int spd);
        if (dut == 0) begin
            bus0.i_up = u; bus0.i_down = d; bus0.i_left = l; bus0.i_right = r;
            bus0.i_speed = 3'(spd);
        end else begin
            bus1.i_up = u; bus1.i_down = d; bus1.i_left = l; bus1.i_right = r;
            bus1.i_speed = 3'(spd);
        end
    endtask

    // One vsync pulse; counts cycles of o_bounce and o_busy seen on the chosen instance.
    task automatic frame(input int dut, output int bnc, output int busy);
        bnc  = 0;
        busy = 0;
        @(negedge clk);
        if (dut == 0) bus0.i_vsync = 1'b1; else bus1.i_vsync = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dut == 0) begin
                bnc  += int'(bus0.o_bounce);
                busy += int'(bus0.o_busy);
            end else begin
                bnc  += int'(bus1.o_bounce);
                busy += int'(bus1.o_busy);
            end
            if (i == 1) begin
                if (dut == 0) bus0.i_vsync = 1'b0; else bus1.i_vsync = 1'b0;
            end
        end
    endtask

    rv_t rtab[8];
    mv_t mtab[8];

    initial begin
        int bnc;
        int busy;
        int tot;
        int ex;
        int ey;

        rtab[0] = '{1'b1, 312, 232, 7, 5};
        rtab[1] = '{1'b1, 328, 232, 0, 2};
        rtab[2] = '{1'b1, 327, 247, 7, 5};
        rtab[3] = '{1'b1, 311, 232, 0, 2};
        rtab[4] = '{1'b1, 312, 248, 0, 2};
        rtab[5] = '{1'b1, 320, 231, 0, 2};
        rtab[6] = '{1'b0, 312, 232, 0, 0};
        rtab[7] = '{1'b1, 0,   0,   0, 2};

        mtab[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 314, 232};
        mtab[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 5, 309, 232};
        mtab[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 7, 309, 232};
        mtab[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 309, 235};
        mtab[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 7, 309, 228};
        mtab[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 310, 228};
        mtab[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 7, 310, 228};
        mtab[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 310, 228};

        rst0 = 1'b1;
        rst1 = 1'b1;
        bus0.i_vsync = 1'b1; bus0.i_visible = 1'b0; bus0.i_hpos = '0; bus0.i_vpos = '0;
        bus1.i_vsync = 1'b0; bus1.i_visible = 1'b0; bus1.i_hpos = '0; bus1.i_vpos = '0;
        btn(0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        btn(1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Reset values appear before any clock edge.
        #2;
        chk("rst_x", int'(bus0.o_ball_x), 312);
        chk("rst_y", int'(bus0.o_ball_y), 232);
        chk("rst_rgb", int'(bus0.o_rgb), 0);
        chk("rst_busy", int'(bus0.o_busy), 0);
        chk("rst_bounce", int'(bus1.o_bounce), 0);

        // vsync held high across release must not start an update.
        @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;
        busy = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            busy += int'(bus0.o_busy);
        end
        chk("no_spurious_tick", busy, 0);
        chk("post_rst_x", int'(bus0.o_ball_x), 312);
        bus0.i_vsync = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus0.i_visible = rtab[i].vis; bus0.i_hpos = 10'(rtab[i].h);
            bus0.i_vpos = 10'(rtab[i].v);
            bus1.i_visible = rtab[i].vis; bus1.i_hpos = 10'(rtab[i].h);
            bus1.i_vpos = 10'(rtab[i].v);
            @(posedge clk);
            #1;
            chk($sformatf("rgb0[%0d]", i), int'(bus0.o_rgb), rtab[i].e0);
            chk($sformatf("rgb1[%0d]", i), int'(bus1.o_rgb), rtab[i].e1);
        end

        // Colour must lag the pixel inputs by one clock.
        @(negedge clk);
        bus0.i_visible = 1'b0;
        @(negedge clk);
        bus0.i_visible = 1'b1; bus0.i_hpos = 10'd315; bus0.i_vpos = 10'd240;
        #1;
        chk("rgb_latency_before", int'(bus0.o_rgb), 0);
        @(posedge clk);
        #1;
        chk("rgb_latency_after", int'(bus0.o_rgb), 7);
        bus0.i_visible = 1'b0;

        for (int i = 0; i < 8; i++) begin
            btn(0, mtab[i].u, mtab[i].d, mtab[i].l, mtab[i].r, mtab[i].spd);
            frame(0, bnc, busy);
            chk($sformatf("mv_x[%0d]", i), int'(bus0.o_ball_x), mtab[i].ex);
            chk($sformatf("mv_y[%0d]", i), int'(bus0.o_ball_y), mtab[i].ey);
        end
        chk("mv_busy_cycles", busy, 3);

        // Second vsync edge arrives during UPD_Y and must be dropped.
        btn(0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        busy = 0;
        @(negedge clk); bus0.i_vsync = 1'b1;
        @(negedge clk); bus0.i_vsync = 1'b0; busy += int'(bus0.o_busy);
        @(negedge clk); bus0.i_vsync = 1'b1; busy += int'(bus0.o_busy);
        @(negedge clk); bus0.i_vsync = 1'b0; busy += int'(bus0.o_busy);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            busy += int'(bus0.o_busy);
        end
        chk("double_tick_busy", busy, 3);
        chk("double_tick_x", int'(bus0.o_ball_x), 311);

        btn(0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        ex  = 311;
        tot = 0;
        for (int i = 0; i < 200; i++) begin
            frame(0, bnc, busy);
            tot += bnc;
            ex = (ex + 2 > 624) ? 624 : ex + 2;
            chk($sformatf("sat_x[%0d]", i), int'(bus0.o_ball_x), ex);
        end
        chk("sat_x_final", int'(bus0.o_ball_x), 624);
        chk("m0_no_bounce", tot, 0);

        btn(0, 1'b0, 1'b0, 1'b1, 1'b1, 2);
        frame(0, bnc, busy);
        chk("lr_both_x", int'(bus0.o_ball_x), 624);

        btn(0, 1'b1, 1'b0, 1'b0, 1'b0, 7);
        for (int i = 0; i < 40; i++) frame(0, bnc, busy);
        chk("up_floor_y", int'(bus0.o_ball_y), 0);
        chk("up_floor_x", int'(bus0.o_ball_x), 624);

        // Reset asserted while the FSM sits in UPD_Y.
        btn(0, 1'b0, 1'b1, 1'b1, 1'b0, 4);
        @(negedge clk); bus0.i_vsync = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("mid_upd_x", int'(bus0.o_ball_x), 620);
        chk("mid_upd_busy", int'(bus0.o_busy), 1);
        rst0 = 1'b1;
        #1;
        chk("async_rst_x", int'(bus0.o_ball_x), 312);
        chk("async_rst_y", int'(bus0.o_ball_y), 232);
        chk("async_rst_busy", int'(bus0.o_busy), 0);
        @(negedge clk);
        rst0 = 1'b0;
        bus0.i_vsync = 1'b0;
        busy = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            busy += int'(bus0.o_busy);
        end
        chk("after_abort_busy", busy, 0);
        chk("after_abort_y", int'(bus0.o_ball_y), 232);

        // Bounce mode: x climbs 2/frame to 622; y bounces once off the bottom at frame 116.
        btn(1, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        tot = 0;
        for (int i = 0; i < 155; i++) begin
            frame(1, bnc, busy);
            tot += bnc;
        end
        chk("b_x_622", int'(bus1.o_ball_x), 622);
        chk("b_y_386", int'(bus1.o_ball_y), 386);
        chk("b_ybounce_cnt", tot, 1);

        btn(1, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        frame(1, bnc, busy);
        chk("b_hit_x", int'(bus1.o_ball_x), 624);
        chk("b_hit_y", int'(bus1.o_ball_y), 382);
        chk("b_hit_pulse", bnc, 1);
        chk("b_hit_busy", busy, 3);
        frame(1, bnc, busy);
        chk("b_ret_x", int'(bus1.o_ball_x), 620);
        chk("b_ret_pulse", bnc, 0);

        btn(1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        frame(1, bnc, busy);
        chk("b_spd0_x", int'(bus1.o_ball_x), 620);
        chk("b_spd0_pulse", bnc, 0);

        btn(1, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        frame(1, bnc, busy);
        chk("b_steer_x", int'(bus1.o_ball_x), 624);
        chk("b_steer_y", int'(bus1.o_ball_y), 374);
        chk("b_steer_pulse", bnc, 1);

        btn(1, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        frame(1, bnc, busy);
        chk("b_after_steer_x", int'(bus1.o_ball_x), 620);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
